// File: rtl/prog_loader_uart_pkg.sv
// Shared definitions for the serial program loader: frame constants,
// loader/receiver state encodings and the frame-length decode helper.
package prog_loader_uart_pkg;

    localparam int         PROG_AW       = 8;
    localparam int         DATA_W        = 8;
    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        CSUM,
        DONE
    } ld_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    // A length byte of zero encodes a full 256-byte image.
    function automatic logic [8:0] frame_len(input logic [7:0] len_byte);
        return (len_byte == 8'd0) ? 9'd256 : {1'b0, len_byte};
    endfunction

endpackage

// File: rtl/prog_loader_uart_if.sv
// Program BRAM port A write bus plus CPU control/status lines driven by the loader.
interface prog_loader_uart_if;
    import prog_loader_uart_pkg::*;

    logic               ram_we;
    logic [PROG_AW-1:0] ram_addr;
    logic [DATA_W-1:0]  ram_data;
    logic               cpu_hold;
    logic               load_ok;
    logic               load_err;

    modport master (
        output ram_we, ram_addr, ram_data, cpu_hold, load_ok, load_err
    );

    modport slave (
        input ram_we, ram_addr, ram_data, cpu_hold, load_ok, load_err
    );

endinterface

// File: rtl/prog_loader_uart_rx.sv
// 8N1 UART byte receiver: 2-flop synchroniser, half-bit start re-check,
// mid-bit sampling LSB first, one-cycle byte_valid or frame_err at mid-stop-bit.
module uart_rx_byte
    import prog_loader_uart_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] rx_byte,
    output logic       frame_err
);

    localparam int             DIV       = CLK_HZ / BAUD;
    localparam int             HALF      = DIV / 2;
    localparam int             CW        = (DIV > 2) ? $clog2(DIV) : 2;
    localparam logic [CW-1:0]  DIV_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0]  HALF_LAST = CW'(HALF - 1);

    logic          rx_meta_q;
    logic          rx_sync_q;
    rx_state_e     st_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;
    logic          vld_q;
    logic          ferr_q;

    // Synchronise the line and walk start/data/stop bits on the bit-period counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            st_q      <= RX_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            vld_q     <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            vld_q     <= 1'b0;
            ferr_q    <= 1'b0;
            case (st_q)
                RX_IDLE: begin
                    if (!rx_sync_q) begin
                        st_q  <= RX_START;
                        cnt_q <= '0;
                    end
                end
                RX_START: begin
                    if (cnt_q == HALF_LAST) begin
                        // A line already high again at half-bit was a glitch.
                        cnt_q <= '0;
                        bit_q <= '0;
                        st_q  <= rx_sync_q ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                RX_DATA: begin
                    if (cnt_q == DIV_LAST) begin
                        cnt_q   <= '0;
                        shift_q <= {rx_sync_q, shift_q[7:1]};
                        bit_q   <= bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            st_q <= RX_STOP;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                RX_STOP: begin
                    if (cnt_q == DIV_LAST) begin
                        cnt_q  <= '0;
                        st_q   <= RX_IDLE;
                        vld_q  <= rx_sync_q;
                        ferr_q <= !rx_sync_q;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: st_q <= RX_IDLE;
            endcase
        end
    end

    assign byte_valid = vld_q;
    assign rx_byte    = shift_q;
    assign frame_err  = ferr_q;

endmodule

// File: rtl/prog_loader_uart.sv
// Serial bootloader: receives SYNC/LEN/data/CSUM frames over UART, writes the
// image into program BRAM from address 0 and releases the CPU on a good checksum.
module prog_loader_uart
    import prog_loader_uart_pkg::*;
#(
    parameter int         CLK_HZ      = 50_000_000,
    parameter int         BAUD        = 115200,
    parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF,
    parameter int         TIMEOUT_CYC = 1_000_000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                uart_rx,
    prog_loader_uart_if.master  bram
);

    localparam int            TW       = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    logic               byte_valid;
    logic [7:0]         rx_byte;
    logic               frame_err;

    ld_state_e          state_q;
    logic [8:0]         cnt_q;
    logic [7:0]         csum_q;
    logic [TW-1:0]      tmr_q;
    logic               ram_we_q;
    logic [PROG_AW-1:0] ram_addr_q;
    logic [DATA_W-1:0]  ram_data_q;
    logic               cpu_hold_q;
    logic               load_ok_q;
    logic               load_err_q;
    logic               in_frame;

    uart_rx_byte #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD)
    ) u_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (uart_rx),
        .byte_valid (byte_valid),
        .rx_byte    (rx_byte),
        .frame_err  (frame_err)
    );

    assign in_frame = (state_q == LEN) || (state_q == DATA) || (state_q == CSUM);

    // Loader FSM with byte counter, checksum, inter-byte timeout and registered BRAM/CPU outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            csum_q     <= '0;
            tmr_q      <= '0;
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_data_q <= '0;
            cpu_hold_q <= 1'b1;
            load_ok_q  <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            ram_we_q   <= 1'b0;
            load_err_q <= 1'b0;

            // Address advances in the cycle after each write strobe, so the
            // 256th write naturally wraps it back to zero.
            if (ram_we_q) begin
                ram_addr_q <= ram_addr_q + PROG_AW'(1);
            end

            if (in_frame && !byte_valid) begin
                tmr_q <= tmr_q + TW'(1);
            end else begin
                tmr_q <= '0;
            end

            case (state_q)
                IDLE: begin
                    if (byte_valid && rx_byte == SYNC_BYTE) begin
                        state_q <= LEN;
                    end
                end
                LEN: begin
                    if (byte_valid) begin
                        cnt_q      <= frame_len(rx_byte);
                        csum_q     <= '0;
                        ram_addr_q <= '0;
                        state_q    <= DATA;
                    end
                end
                DATA: begin
                    if (byte_valid) begin
                        ram_data_q <= rx_byte;
                        ram_we_q   <= 1'b1;
                        csum_q     <= csum_q + rx_byte;
                        cnt_q      <= cnt_q - 9'd1;
                        if (cnt_q == 9'd1) begin
                            state_q <= CSUM;
                        end
                    end
                end
                CSUM: begin
                    if (byte_valid) begin
                        if (rx_byte == csum_q) begin
                            state_q    <= DONE;
                            cpu_hold_q <= 1'b0;
                            load_ok_q  <= 1'b1;
                        end else begin
                            state_q    <= IDLE;
                            load_err_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (byte_valid && rx_byte == SYNC_BYTE) begin
                        state_q    <= LEN;
                        cpu_hold_q <= 1'b1;
                        load_ok_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase

            // Abort on framing error or inter-byte timeout; a byte arriving on
            // the expiry cycle takes precedence and restarts the timer.
            if (in_frame && !byte_valid && (frame_err || tmr_q == TMO_LAST)) begin
                state_q    <= IDLE;
                load_err_q <= 1'b1;
            end
        end
    end

    assign bram.ram_we   = ram_we_q;
    assign bram.ram_addr = ram_addr_q;
    assign bram.ram_data = ram_data_q;
    assign bram.cpu_hold = cpu_hold_q;
    assign bram.load_ok  = load_ok_q;
    assign bram.load_err = load_err_q;

endmodule

// File: tb/tb_prog_loader_uart.sv
// Directed bench for prog_loader_uart: per-byte vector table plus hand-written
// sequences for the 256-byte image, timeout and mid-frame reset.
module tb_prog_loader_uart;

    localparam int CLK_HZ = 800_000;
    localparam int BAUD   = 100_000;
    localparam int DIV    = CLK_HZ / BAUD;
    localparam int TMO    = 500;

    typedef struct {
        logic [7:0] b;
        logic       stop;
        int         nwr;
        logic [7:0] addr;
        logic [7:0] data;
        logic       hold;
        logic       ok;
        int         nerr;
    } vec_t;

    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic uart_rx = 1'b1;

    int n_chk  = 0;
    int n_fail = 0;

    int         wr_total  = 0;
    int         err_total = 0;
    logic [7:0] last_addr = 8'h00;
    logic [7:0] last_data = 8'h00;

    prog_loader_uart_if bus ();

    prog_loader_uart #(
        .CLK_HZ      (CLK_HZ),
        .BAUD        (BAUD),
        .SYNC_BYTE   (8'hA5),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .uart_rx (uart_rx),
        .bram    (bus)
    );

    always #5 clk = ~clk;

    // Record every write strobe and error pulse, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.ram_we) begin
            wr_total  <= wr_total + 1;
            last_addr <= bus.ram_addr;
            last_data <= bus.ram_data;
        end
        if (bus.load_err) begin
            err_total <= err_total + 1;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic vec_t mk(input logic [7:0] b, input logic stop, input int nwr,
                                input logic [7:0] addr, input logic [7:0] data,
                                input logic hold, input logic ok, input int nerr);
        vec_t v;
        v.b = b; v.stop = stop; v.nwr = nwr; v.addr = addr; v.data = data;
        v.hold = hold; v.ok = ok; v.nerr = nerr;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        uart_rx = 1'b0;
        tick(DIV);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            tick(DIV);
        end
        uart_rx = stop;
        tick(DIV);
        uart_rx = 1'b1;
        tick(2 * DIV);
    endtask

    task automatic apply(input vec_t v, input string nm);
        int w0;
        int e0;
        w0 = wr_total;
        e0 = err_total;
        send_byte(v.b, v.stop);
        chk({nm, "_nwr"}, wr_total - w0, v.nwr);
        if (v.nwr > 0) begin
            chk({nm, "_addr"}, int'(last_addr), int'(v.addr));
            chk({nm, "_data"}, int'(last_data), int'(v.data));
        end
        chk({nm, "_hold"}, int'(bus.cpu_hold), int'(v.hold));
        chk({nm, "_ok"},   int'(bus.load_ok),  int'(v.ok));
        chk({nm, "_err"},  err_total - e0, v.nerr);
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_we"},   int'(bus.ram_we),   0);
        chk({nm, "_addr"}, int'(bus.ram_addr), 0);
        chk({nm, "_data"}, int'(bus.ram_data), 0);
        chk({nm, "_hold"}, int'(bus.cpu_hold), 1);
        chk({nm, "_ok"},   int'(bus.load_ok),  0);
        chk({nm, "_err"},  int'(bus.load_err), 0);
    endtask

    initial begin
        vec_t tbl[$];
        int   e0;
        int   w0;

        // Good 3-byte frame
        tbl.push_back(mk(8'hA5, 1'b1, 0, 8'h00, 8'h00, 1'b1, 1'b0, 0));
        tbl.push_back(mk(8'h03, 1'b1, 0, 8'h00, 8'h00, 1'b1, 1'b0, 0));
        tbl.push_back(mk(8'h10, 1'b1, 1, 8'h00, 8'h10, 1'b1, 1'b0, 0));
        tbl.push_back(mk(8'h20, 1'b1, 1, 8'h01, 8'h20, 1'b1, 1'b0, 0));
        tbl.push_back(mk(8'h30, 1'b1, 1, 8'h02, 8'h30, 1'b1, 1'b0, 0));
        tbl.push_back(mk(8'h60, 1'b1, 0, 8'h00, 8'h00, 1'b0, 1'b1, 0));
        // Bad checksum
        tbl.push_back(mk(8'hA5, 1'b1, 0, 8'h00, 8'h00, 1'b1, 1'b0, 0));
        tbl.push_back(mk(8'h02, 1'b1, 0, 8'h00, 8'h00, 1'b1, 1'b0, 0));
        tbl.push_back(mk(8'h01, 1'b1, 1, 8'h00, 8'h01, 1'b1, 1'b0, 0));
        tbl.push_back(mk(8'h02, 1'b1, 1, 8'h01, 8'h02, 1'b1, 1'b0, 0));
        tbl.push_back(mk(8'hFF, 1'b1, 0, 8'h00, 8'h00, 1'b1, 1'b0, 1));
        // Junk before SYNC is ignored
        tbl.push_back(mk(8'h55, 1'b1, 0, 8'h00, 8'h00, 1'b1, 1'b0, 0));
        tbl.push_back(mk(8'hA5, 1'b1, 0, 8'h00, 8'h00, 1'b1, 1'b0, 0));
        tbl.push_back(mk(8'h01, 1'b1, 0, 8'h00, 8'h00, 1'b1, 1'b0, 0));
        tbl.push_back(mk(8'h7E, 1'b1, 1, 8'h00, 8'h7E, 1'b1, 1'b0, 0));
        tbl.push_back(mk(8'h7E, 1'b1, 0, 8'h00, 8'h00, 1'b0, 1'b1, 0));
        // Reload from DONE
        tbl.push_back(mk(8'hA5, 1'b1, 0, 8'h00, 8'h00, 1'b1, 1'b0, 0));
        tbl.push_back(mk(8'h01, 1'b1, 0, 8'h00, 8'h00, 1'b1, 1'b0, 0));
        tbl.push_back(mk(8'h42, 1'b1, 1, 8'h00, 8'h42, 1'b1, 1'b0, 0));
        tbl.push_back(mk(8'h42, 1'b1, 0, 8'h00, 8'h00, 1'b0, 1'b1, 0));
        // Framing error inside DATA, then recovery
        tbl.push_back(mk(8'hA5, 1'b1, 0, 8'h00, 8'h00, 1'b1, 1'b0, 0));
        tbl.push_back(mk(8'h02, 1'b1, 0, 8'h00, 8'h00, 1'b1, 1'b0, 0));
        tbl.push_back(mk(8'h33, 1'b1, 1, 8'h00, 8'h33, 1'b1, 1'b0, 0));
        tbl.push_back(mk(8'h44, 1'b0, 0, 8'h00, 8'h00, 1'b1, 1'b0, 1));
        tbl.push_back(mk(8'hA5, 1'b1, 0, 8'h00, 8'h00, 1'b1, 1'b0, 0));
        tbl.push_back(mk(8'h01, 1'b1, 0, 8'h00, 8'h00, 1'b1, 1'b0, 0));
        tbl.push_back(mk(8'h09, 1'b1, 1, 8'h00, 8'h09, 1'b1, 1'b0, 0));
        tbl.push_back(mk(8'h09, 1'b1, 0, 8'h00, 8'h00, 1'b0, 1'b1, 0));

        // Reset state
        rst_n = 1'b0;
        tick(4);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        tick(4 * DIV);

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("vec%0d", i));
        end

        // Full 256-byte image (LEN=0), address wraps back to 0 at the end
        apply(mk(8'hA5, 1'b1, 0, 8'h00, 8'h00, 1'b1, 1'b0, 0), "big_sync");
        apply(mk(8'h00, 1'b1, 0, 8'h00, 8'h00, 1'b1, 1'b0, 0), "big_len");
        for (int i = 0; i < 256; i++) begin
            apply(mk(8'h01, 1'b1, 1, 8'(i), 8'h01, 1'b1, 1'b0, 0), $sformatf("big_d%0d", i));
        end
        apply(mk(8'h00, 1'b1, 0, 8'h00, 8'h00, 1'b0, 1'b1, 0), "big_csum");
        chk("big_addr_wrap", int'(bus.ram_addr), 0);

        // Inter-byte timeout
        apply(mk(8'hA5, 1'b1, 0, 8'h00, 8'h00, 1'b1, 1'b0, 0), "tmo_sync");
        apply(mk(8'h04, 1'b1, 0, 8'h00, 8'h00, 1'b1, 1'b0, 0), "tmo_len");
        apply(mk(8'h11, 1'b1, 1, 8'h00, 8'h11, 1'b1, 1'b0, 0), "tmo_d0");
        e0 = err_total;
        tick(400);
        chk("tmo_early_err", err_total - e0, 0);
        tick(300);
        chk("tmo_err", err_total - e0, 1);
        chk("tmo_hold", int'(bus.cpu_hold), 1);
        chk("tmo_ok", int'(bus.load_ok), 0);
        apply(mk(8'hA5, 1'b1, 0, 8'h00, 8'h00, 1'b1, 1'b0, 0), "tmo2_sync");
        apply(mk(8'h01, 1'b1, 0, 8'h00, 8'h00, 1'b1, 1'b0, 0), "tmo2_len");
        apply(mk(8'h5A, 1'b1, 1, 8'h00, 8'h5A, 1'b1, 1'b0, 0), "tmo2_d0");
        apply(mk(8'h5A, 1'b1, 0, 8'h00, 8'h00, 1'b0, 1'b1, 0), "tmo2_csum");

        // Reset while the second data byte is on the line
        apply(mk(8'hA5, 1'b1, 0, 8'h00, 8'h00, 1'b1, 1'b0, 0), "rst_sync");
        apply(mk(8'h03, 1'b1, 0, 8'h00, 8'h00, 1'b1, 1'b0, 0), "rst_len");
        apply(mk(8'h11, 1'b1, 1, 8'h00, 8'h11, 1'b1, 1'b0, 0), "rst_d0");
        e0 = err_total;
        w0 = wr_total;
        uart_rx = 1'b0;
        tick(DIV);
        uart_rx = 1'b0;
        tick(DIV);
        uart_rx = 1'b1;
        tick(DIV / 2);
        rst_n = 1'b0;
        tick(2);
        chk_reset_outputs("midrst");
        rst_n = 1'b1;
        tick(30 * DIV);
        chk("midrst_no_err", err_total - e0, 0);
        chk("midrst_no_wr", wr_total - w0, 0);
        apply(mk(8'hA5, 1'b1, 0, 8'h00, 8'h00, 1'b1, 1'b0, 0), "post_sync");
        apply(mk(8'h02, 1'b1, 0, 8'h00, 8'h00, 1'b1, 1'b0, 0), "post_len");
        apply(mk(8'hC3, 1'b1, 1, 8'h00, 8'hC3, 1'b1, 1'b0, 0), "post_d0");
        apply(mk(8'h3C, 1'b1, 1, 8'h01, 8'h3C, 1'b1, 1'b0, 0), "post_d1");
        apply(mk(8'hFF, 1'b1, 0, 8'h00, 8'h00, 1'b0, 1'b1, 0), "post_csum");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
